// File: rtl/c2f_consumer.sv
// Rate-limited consumer for the CPU-to-FPGA chunk queue: reads QWs chunk by chunk,
// folds them into a 64-bit checksum and releases each chunk through rdPtr_out.
module c2f_consumer #(
    parameter int PTR_WIDTH  = 2,
    parameter int CHUNK_QWS  = 512,
    parameter int ADDR_WIDTH = PTR_WIDTH + $clog2(CHUNK_QWS)
) (
    input  logic                  clk_in,
    input  logic                  reset_in,
    input  logic                  clear_in,
    input  logic [31:0]           rate_in,
    input  logic [PTR_WIDTH-1:0]  wrPtr_in,
    output logic [ADDR_WIDTH-1:0] ramAddr_out,
    output logic                  ramRdEn_out,
    input  logic [63:0]           ramData_in,
    output logic [PTR_WIDTH-1:0]  rdPtr_out,
    output logic                  rdPtrUpdate_out,
    output logic [63:0]           checksum_out,
    output logic                  busy_out
);

    localparam int QW_W = $clog2(CHUNK_QWS);
    localparam logic [QW_W-1:0] QW_LAST = QW_W'(CHUNK_QWS - 1);

    logic [PTR_WIDTH-1:0]  issPtr_q,   issPtr_d;
    logic [QW_W-1:0]       qwIdx_q,    qwIdx_d;
    logic [31:0]           rateCnt_q,  rateCnt_d;
    logic                  pendLast_q, pendLast_d;
    logic                  rdEn_q,     rdEn_d;
    logic                  accPend_q,  accPend_d;
    logic [ADDR_WIDTH-1:0] addr_q,     addr_d;
    logic [PTR_WIDTH-1:0]  rdPtr_q,    rdPtr_d;
    logic                  rdPtrUpd_q, rdPtrUpd_d;
    logic [63:0]           checksum_q, checksum_d;
    logic                  issue;

    // The issue gate is re-evaluated for every QW, so an unpublished chunk is never started.
    assign issue = (rate_in != 32'd0) && (rateCnt_q == 32'd0) && (issPtr_q != wrPtr_in);

    always_comb begin
        issPtr_d   = issPtr_q;
        qwIdx_d    = qwIdx_q;
        rateCnt_d  = rateCnt_q;
        pendLast_d = pendLast_q;
        addr_d     = addr_q;
        rdPtr_d    = rdPtr_q;
        checksum_d = checksum_q;
        rdEn_d     = issue;
        accPend_d  = rdEn_q;
        rdPtrUpd_d = 1'b0;

        // The chunk is released on the edge where the RAM captures its last read.
        if (rdEn_q && pendLast_q) begin
            rdPtr_d    = rdPtr_q + 1'b1;
            rdPtrUpd_d = 1'b1;
            pendLast_d = 1'b0;
        end

        if (issue) begin
            addr_d    = {issPtr_q, qwIdx_q};
            rateCnt_d = rate_in - 32'd1;
            if (qwIdx_q == QW_LAST) begin
                qwIdx_d    = '0;
                issPtr_d   = issPtr_q + 1'b1;
                pendLast_d = 1'b1;
            end else begin
                qwIdx_d = qwIdx_q + 1'b1;
            end
        end else if ((rate_in != 32'd0) && (rateCnt_q != 32'd0)) begin
            rateCnt_d = rateCnt_q - 32'd1;
        end

        if (accPend_q) begin
            checksum_d = checksum_q + ramData_in;
        end
    end

    // Soft clear shares the reset values, which also drops any QW still in flight.
    always_ff @(posedge clk_in or posedge reset_in) begin
        if (reset_in) begin
            issPtr_q   <= '0;
            qwIdx_q    <= '0;
            rateCnt_q  <= '0;
            pendLast_q <= 1'b0;
            rdEn_q     <= 1'b0;
            accPend_q  <= 1'b0;
            addr_q     <= '0;
            rdPtr_q    <= '0;
            rdPtrUpd_q <= 1'b0;
            checksum_q <= '0;
        end else if (clear_in) begin
            issPtr_q   <= '0;
            qwIdx_q    <= '0;
            rateCnt_q  <= '0;
            pendLast_q <= 1'b0;
            rdEn_q     <= 1'b0;
            accPend_q  <= 1'b0;
            addr_q     <= '0;
            rdPtr_q    <= '0;
            rdPtrUpd_q <= 1'b0;
            checksum_q <= '0;
        end else begin
            issPtr_q   <= issPtr_d;
            qwIdx_q    <= qwIdx_d;
            rateCnt_q  <= rateCnt_d;
            pendLast_q <= pendLast_d;
            rdEn_q     <= rdEn_d;
            accPend_q  <= accPend_d;
            addr_q     <= addr_d;
            rdPtr_q    <= rdPtr_d;
            rdPtrUpd_q <= rdPtrUpd_d;
            checksum_q <= checksum_d;
        end
    end

    assign ramAddr_out     = addr_q;
    assign ramRdEn_out     = rdEn_q;
    assign rdPtr_out       = rdPtr_q;
    assign rdPtrUpdate_out = rdPtrUpd_q;
    assign checksum_out    = checksum_q;
    assign busy_out        = (qwIdx_q != '0) || rdEn_q || accPend_q;

endmodule

// File: tb/tb_c2f_consumer.sv
// Self-checking bench for c2f_consumer: a host/RAM model publishes chunks and a
// queue-based scoreboard predicts addresses, releases and the checksum.
module tb_c2f_consumer;

    localparam int PW = 2;
    localparam int CQ = 8;
    localparam int AW = 5;
    localparam int NQ = 32;

    logic           clk_in = 1'b0;
    logic           reset_in;
    logic           clear_in;
    logic [31:0]    rate_in;
    logic [PW-1:0]  wrPtr_in;
    logic [AW-1:0]  ramAddr_out;
    logic           ramRdEn_out;
    logic [63:0]    ramData_in;
    logic [PW-1:0]  rdPtr_out;
    logic           rdPtrUpdate_out;
    logic [63:0]    checksum_out;
    logic           busy_out;

    c2f_consumer #(.PTR_WIDTH(PW), .CHUNK_QWS(CQ)) dut (
        .clk_in          (clk_in),
        .reset_in        (reset_in),
        .clear_in        (clear_in),
        .rate_in         (rate_in),
        .wrPtr_in        (wrPtr_in),
        .ramAddr_out     (ramAddr_out),
        .ramRdEn_out     (ramRdEn_out),
        .ramData_in      (ramData_in),
        .rdPtr_out       (rdPtr_out),
        .rdPtrUpdate_out (rdPtrUpdate_out),
        .checksum_out    (checksum_out),
        .busy_out        (busy_out)
    );

    always #5 clk_in = ~clk_in;

    logic [63:0] mem [NQ];
    int          checkCount = 0;
    int          errorCount = 0;
    int          cyc = 0;
    bit          monEn = 1'b0;
    int          issuedTotal = 0;
    int          releasedTotal = 0;
    int          publishedChunks = 0;
    logic [63:0] expSum = '0;
    int          strobeCycles[$];
    int          strobeAddrs[$];
    int          pulseCycles[$];

    // Synchronous RAM: data appears the cycle after the strobe.
    always @(posedge clk_in) begin
        cyc <= cyc + 1;
        if (ramRdEn_out) ramData_in <= mem[ramAddr_out];
    end

    task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
        checkCount++;
        if (actual !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    // Scoreboard: every strobe must be the next QW in chunk order, every release must follow a full chunk.
    always @(negedge clk_in) begin
        if (monEn) begin
            if (rdPtrUpdate_out) begin
                checkOutput("pulse_rdptr", 64'(rdPtr_out), 64'((releasedTotal + 1) % 4));
                checkOutput("pulse_after_chunk", 64'(issuedTotal), 64'((releasedTotal + 1) * CQ));
                releasedTotal++;
                pulseCycles.push_back(cyc);
            end
            if (ramRdEn_out) begin
                checkOutput("strobe_addr", 64'(ramAddr_out), 64'(issuedTotal % NQ));
                checkOutput("strobe_published", 64'(issuedTotal < publishedChunks * CQ), 64'(1));
                strobeCycles.push_back(cyc);
                strobeAddrs.push_back(int'(ramAddr_out));
                issuedTotal++;
            end
        end
    end

    task automatic tick();
        @(negedge clk_in);
        #1;
    endtask

    task automatic resetModel();
        issuedTotal     = 0;
        releasedTotal   = 0;
        publishedChunks = 0;
        expSum          = '0;
        strobeCycles.delete();
        strobeAddrs.delete();
        pulseCycles.delete();
    endtask

    // mode 0: all ones, 1: all-FF, 2: random
    task automatic publishChunk(input int mode);
        int slot;
        logic [63:0] v;
        slot = publishedChunks % 4;
        for (int q = 0; q < CQ; q++) begin
            case (mode)
                0:       v = 64'd1;
                1:       v = '1;
                default: v = {$urandom, $urandom};
            endcase
            mem[slot * CQ + q] = v;
            expSum += v;
        end
        publishedChunks++;
        wrPtr_in = PW'(publishedChunks % 4);
    endtask

    task automatic applyStimulus(input int rate, input int nChunks, input int mode);
        strobeCycles.delete();
        strobeAddrs.delete();
        pulseCycles.delete();
        rate_in = 32'(rate);
        for (int i = 0; i < nChunks; i++) publishChunk(mode);
    endtask

    task automatic waitDrain(input int target, input int budget, input string tag);
        int n;
        n = 0;
        while (!(issuedTotal == target && !busy_out) && n < budget) begin
            tick();
            n++;
        end
        checkOutput({tag, "_timeout"}, 64'(n >= budget), 64'(0));
    endtask

    task automatic waitIssued(input int target, input int budget, input string tag);
        int n;
        n = 0;
        while (issuedTotal < target && n < budget) begin
            tick();
            n++;
        end
        checkOutput({tag, "_timeout"}, 64'(n >= budget), 64'(0));
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, "_rden"}, 64'(ramRdEn_out), 64'(0));
        checkOutput({tag, "_addr"}, 64'(ramAddr_out), 64'(0));
        checkOutput({tag, "_rdptr"}, 64'(rdPtr_out), 64'(0));
        checkOutput({tag, "_upd"}, 64'(rdPtrUpdate_out), 64'(0));
        checkOutput({tag, "_sum"}, checksum_out, 64'(0));
        checkOutput({tag, "_busy"}, 64'(busy_out), 64'(0));
    endtask

    initial begin
        int nonzeroSeen, badGaps, n, rate, k, pauseOn, base, seenPulse;
        for (int i = 0; i < NQ; i++) mem[i] = '0;
        ramData_in = '0;
        reset_in   = 1'b1;
        clear_in   = 1'b0;
        rate_in    = '0;
        wrPtr_in   = '0;
        repeat (3) tick();
        checkAllZero("reset");

        // Stalled consumer with a published chunk.
        reset_in = 1'b0;
        monEn    = 1'b1;
        applyStimulus(0, 1, 0);
        nonzeroSeen = 0;
        for (int i = 0; i < 1000; i++) begin
            tick();
            if (ramRdEn_out || ramAddr_out != '0 || rdPtr_out != '0 || rdPtrUpdate_out ||
                checksum_out != '0 || busy_out) nonzeroSeen++;
        end
        checkOutput("stall_strobes", 64'(issuedTotal), 64'(0));
        checkOutput("stall_outputs", 64'(nonzeroSeen), 64'(0));

        // rate 1: eight back-to-back reads, release one cycle after the last.
        rate_in = 32'd1;
        waitDrain(8, 100, "rate1");
        checkOutput("rate1_count", 64'(strobeCycles.size()), 64'(8));
        checkOutput("rate1_span", 64'(strobeCycles.size() == 8 ? strobeCycles[7] - strobeCycles[0] : -1), 64'(7));
        checkOutput("rate1_pulses", 64'(pulseCycles.size()), 64'(1));
        checkOutput("rate1_pulse_cycle", 64'(pulseCycles.size() > 0 ? pulseCycles[0] : -1),
                    64'(strobeCycles.size() > 0 ? strobeCycles[$] + 1 : -2));
        checkOutput("rate1_sum", checksum_out, 64'd8);
        checkOutput("rate1_rdptr", 64'(rdPtr_out), 64'(1));
        repeat (20) tick();
        checkOutput("rate1_idle", 64'(issuedTotal), 64'(8));
        checkOutput("rate1_busy", 64'(busy_out), 64'(0));

        // rate 4: strobes exactly 4 apart, release 29 cycles after the first.
        applyStimulus(4, 1, 0);
        waitDrain(16, 200, "rate4");
        badGaps = 0;
        for (int i = 1; i < strobeCycles.size(); i++)
            if (strobeCycles[i] - strobeCycles[i-1] != 4) badGaps++;
        checkOutput("rate4_count", 64'(strobeCycles.size()), 64'(8));
        checkOutput("rate4_gaps", 64'(badGaps), 64'(0));
        checkOutput("rate4_release", 64'(pulseCycles.size() > 0 ? pulseCycles[0] : -1),
                    64'(strobeCycles.size() > 0 ? strobeCycles[0] + 29 : -2));
        checkOutput("rate4_sum", checksum_out, 64'd16);
        checkOutput("rate4_rdptr", 64'(rdPtr_out), 64'(2));

        // Pause mid-chunk after QW 3, resume at QW 4.
        applyStimulus(2, 1, 2);
        waitIssued(20, 100, "pause_reach");
        rate_in = '0;
        repeat (50) tick();
        checkOutput("pause_no_issue", 64'(issuedTotal), 64'(20));
        checkOutput("pause_busy", 64'(busy_out), 64'(1));
        rate_in = 32'd2;
        waitDrain(24, 200, "pause");
        checkOutput("pause_resume_addr", 64'(strobeAddrs.size() > 4 ? strobeAddrs[4] : -1), 64'(20));
        checkOutput("pause_sum", checksum_out, expSum);
        checkOutput("pause_rdptr", 64'(rdPtr_out), 64'(3));

        // Clear lands on the last-QW release cycle: it must win.
        applyStimulus(1, 1, 2);
        n = 0;
        while (!(ramRdEn_out && ramAddr_out == AW'(31)) && n < 100) begin
            tick();
            n++;
        end
        checkOutput("clear_reach_timeout", 64'(n >= 100), 64'(0));
        monEn    = 1'b0;
        clear_in = 1'b1;
        tick();
        clear_in = 1'b0;
        resetModel();
        checkAllZero("clear");
        seenPulse = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (rdPtrUpdate_out || rdPtr_out != '0) seenPulse++;
        end
        checkOutput("clear_no_release", 64'(seenPulse), 64'(0));
        checkOutput("clear_sum_after", checksum_out, 64'(0));
        monEn = 1'b1;

        // Asynchronous reset mid-chunk.
        applyStimulus(3, 1, 2);
        waitIssued(3, 100, "areset_reach");
        #1;
        monEn    = 1'b0;
        reset_in = 1'b1;
        #1;
        checkAllZero("areset");
        tick();
        reset_in = 1'b0;
        wrPtr_in = '0;
        resetModel();
        repeat (10) tick();
        checkOutput("areset_rdptr_after", 64'(rdPtr_out), 64'(0));
        checkOutput("areset_sum_after", checksum_out, 64'(0));
        monEn = 1'b1;

        // Pointer wrap across five all-FF chunks.
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1, 1, 1);
            waitDrain((i + 1) * CQ, 100, "wrap");
            checkOutput("wrap_rdptr", 64'(rdPtr_out), 64'((i + 1) % 4));
        end
        checkOutput("wrap_sum", checksum_out, 64'hFFFF_FFFF_FFFF_FFD8);

        // Randomized rounds against the scoreboard.
        for (int r = 0; r < 8; r++) begin
            rate    = int'($urandom_range(1, 5));
            k       = int'($urandom_range(1, 3));
            pauseOn = int'($urandom_range(0, 1));
            base    = issuedTotal;
            applyStimulus(rate, k, 2);
            if (pauseOn != 0) begin
                waitIssued(base + int'($urandom_range(1, k * CQ - 1)), 500, "rand_pause_reach");
                rate_in = '0;
                repeat ($urandom_range(5, 40)) tick();
                rate_in = 32'(rate);
            end
            waitDrain(base + k * CQ, 1000, "rand");
            checkOutput("rand_sum", checksum_out, expSum);
            checkOutput("rand_rdptr", 64'(rdPtr_out), 64'(publishedChunks % 4));
            checkOutput("rand_released", 64'(releasedTotal), 64'(publishedChunks));
            if (pauseOn == 0) begin
                badGaps = 0;
                for (int i = 1; i < strobeCycles.size(); i++)
                    if (strobeCycles[i] - strobeCycles[i-1] != rate) badGaps++;
                checkOutput("rand_gaps", 64'(badGaps), 64'(0));
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
        $finish;
    end

endmodule
